wseq_timing_gen: RTL

//  Clocked generator of the processor's five one-hot timing strobes wseq2..wseq6 (phases T2..T6),

---
 rtl/wseq_pkg.sv | 21 ++
 rtl/wseq_dly_line.sv | 30 +++
 rtl/wseq_timing_gen.sv | 112 +++++++++++
 3 files changed

// File: rtl/wseq_pkg.sv
// Shared definitions for the wseq timing-strobe generator: phase codes,
// phase count and FSM state encoding.
package wseq_pkg;

  localparam int NUM_PHASES = 5;

  // Phase codes as presented on the phase output; IDLE is deliberately
  // outside the 0..4 range so it can never be mistaken for a live phase.
  localparam logic [2:0] PH_T2   = 3'd0;
  localparam logic [2:0] PH_T3   = 3'd1;
  localparam logic [2:0] PH_T4   = 3'd2;
  localparam logic [2:0] PH_T5   = 3'd3;
  localparam logic [2:0] PH_T6   = 3'd4;
  localparam logic [2:0] PH_IDLE = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/wseq_dly_line.sv
// Fixed-length shift register: dout presents din exactly DLY clocks later.
// Cleared only by reset; it has no enable, so the delayed copy keeps its
// exact timing regardless of what the source is doing.
module wseq_dly_line #(
  parameter int WIDTH = 5,
  parameter int DLY   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DLY];

  // Shift din through DLY stages; reset flushes every stage.
  // NOTE: every stage is reset, not just the output one, otherwise stale
  // pulses still in flight would emerge on the delayed side after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DLY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DLY; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DLY-1];

endmodule

// File: rtl/wseq_timing_gen.sv
// Timing-strobe generator: walks one-hot strobes wseq2..wseq6 (T2..T6),
// each held PHASE_CYCLES clocks, with start/stall/stop control, and
// produces a DLY-clock delayed copy of the strobe set.
import wseq_pkg::*;

module wseq_timing_gen #(
  parameter int PHASE_CYCLES = 1,
  parameter int DLY          = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stall,
  input  logic       stop,
  output logic       wseq2,
  output logic       wseq3,
  output logic       wseq4,
  output logic       wseq5,
  output logic       wseq6,
  output logic       dwseq2,
  output logic       dwseq3,
  output logic       dwseq4,
  output logic       dwseq5,
  output logic       dwseq6,
  output logic       busy,
  output logic       cycle_done,
  output logic [2:0] phase
);

  localparam int             CW       = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(PHASE_CYCLES - 1);

  state_e                  state;
  logic [CW-1:0]           cnt;
  logic                    stop_pending;
  logic [NUM_PHASES-1:0]   wseq;
  logic [NUM_PHASES-1:0]   dwseq;
  logic                    phase_last;
  logic                    cycle_end;

  // A phase ends on its last counted clock unless stall holds it; the whole
  // T2..T6 pass ends when that happens in T6.
  assign phase_last = (state == ST_RUN) && !stall && (cnt == CNT_LAST);
  assign cycle_end  = phase_last && (phase == PH_T6);
  assign cycle_done = cycle_end;

  // FSM, phase counter, stop capture and one-hot strobe register.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others, as real flops do.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      stop_pending <= 1'b0;
      wseq         <= '0;
      phase        <= PH_IDLE;
      busy         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_RUN;
            cnt          <= '0;
            stop_pending <= stop;
            wseq         <= NUM_PHASES'(1);
            phase        <= PH_T2;
            busy         <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) stop_pending <= 1'b1;
          if (cycle_end) begin
            cnt <= '0;
            if (stop_pending || stop) begin
              state        <= ST_IDLE;
              stop_pending <= 1'b0;
              wseq         <= '0;
              phase        <= PH_IDLE;
              busy         <= 1'b0;
            end else begin
              wseq  <= NUM_PHASES'(1);
              phase <= PH_T2;
            end
          end else if (phase_last) begin
            cnt   <= '0;
            wseq  <= {wseq[NUM_PHASES-2:0], 1'b0};
            phase <= phase + 3'd1;
          end else if (!stall) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  wseq_dly_line #(
    .WIDTH (NUM_PHASES),
    .DLY   (DLY)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (wseq),
    .dout  (dwseq)
  );

  assign {wseq6, wseq5, wseq4, wseq3, wseq2}      = wseq;
  assign {dwseq6, dwseq5, dwseq4, dwseq3, dwseq2} = dwseq;

endmodule
